mem_line_arbiter: RTL

- Parametrised N-channel successor to the two-port i/d memory arbiter.
- Sits between N_CH line-granular requesters (icache, dcache, prefetcher, ...) and the single cacheline adaptor port.
- Arbitrates one request at a time, using round-robin or fixed priority.
- Registers the winning request and returns the response to the winning channel only.

---
 rtl/mem_line_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_line_arbiter.sv
// N-channel cacheline arbiter in front of a single pmem port.
// Grants one line request at a time (round-robin or fixed priority) and routes the completion back to the winner.
module mem_line_arbiter #(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 256,
    parameter bit          RR_MODE = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*ADDR_W-1:0]   ch_address,
    input  logic [N_CH*LINE_W-1:0]   ch_wdata,
    input  logic [N_CH-1:0]          ch_read,
    input  logic [N_CH-1:0]          ch_write,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [N_CH-1:0]          ch_resp,
    output logic [ADDR_W-1:0]        pmem_address,
    output logic [LINE_W-1:0]        pmem_wdata,
    output logic                     pmem_read,
    output logic                     pmem_write,
    input  logic [LINE_W-1:0]        pmem_rdata,
    input  logic                     pmem_resp,
    output logic [$clog2(N_CH)-1:0]  grant_id,
    output logic                     busy
);
    localparam int unsigned ID_W = $clog2(N_CH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [N_CH-1:0]   req;
    logic              any_req;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   idx;
    logic [ID_W-1:0]   last;
    logic              grant_en;
    logic              done_en;
    logic [ADDR_W-1:0] addr_arr  [N_CH];
    logic [LINE_W-1:0] wdata_arr [N_CH];

    assign req = ch_read | ch_write;

    for (genvar g = 0; g < N_CH; g++) begin : g_unpack
        assign addr_arr[g]  = ch_address[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = ch_wdata[g*LINE_W +: LINE_W];
    end

    // Winner pick: later loop iterations overwrite earlier ones, so the last write is the highest priority.
    always_comb begin
        winner  = '0;
        idx     = '0;
        any_req = 1'b0;
        if (RR_MODE) begin
            for (int k = N_CH; k >= 1; k--) begin
                idx = ID_W'((32'(last) + 32'(k)) % N_CH);
                if (req[idx]) begin
                    winner  = idx;
                    any_req = 1'b1;
                end
            end
        end else begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                idx = ID_W'(k);
                if (req[idx]) begin
                    winner  = idx;
                    any_req = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        done_en    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = BUSY;
                    grant_en   = 1'b1;
                end
            end
            BUSY: begin
                if (pmem_resp) begin
                    state_next = DONE;
                    done_en    = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latched request; a simultaneous read+write on one channel is taken as a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pmem_address <= '0;
            pmem_wdata   <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            busy         <= 1'b0;
            grant_id     <= '0;
            last         <= ID_W'(N_CH - 1);
        end else if (grant_en) begin
            pmem_address <= addr_arr[winner];
            pmem_wdata   <= wdata_arr[winner];
            pmem_write   <= ch_write[winner];
            pmem_read    <= ~ch_write[winner];
            busy         <= 1'b1;
            grant_id     <= winner;
            if (RR_MODE) begin
                last <= winner;
            end
        end else if (done_en) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            busy       <= 1'b0;
        end
    end

    // Completion is steered to the granted channel only while a transaction is outstanding.
    always_comb begin
        ch_resp  = '0;
        ch_rdata = '0;
        if (state == BUSY && pmem_resp) begin
            ch_resp[grant_id] = 1'b1;
            ch_rdata          = pmem_rdata;
        end
    end

endmodule
